// File: rtl/popcount_seq.sv
// ---------------------------------------------------------------------------
// popcount_seq
//
// Sequencing controller around a single 10-to-4 compressor for the
// binary-CNN popcount path. A vector of `len` 10-bit chunks arrives over a
// valid/ready stream. Each chunk is compressed to a 4-bit count (0..10) and
// the counts are accumulated into a saturating sum. The sum is presented on
// a valid/ready result port. Only one vector is in flight at a time.
//
// Build option:
//   POPCNT_XNOR_EN  defined   -> compressor counts ~(chunk_data ^ chunk_wgt),
//                                which is the XNOR match count.
//                   undefined -> compressor counts chunk_data. chunk_wgt is
//                                ignored.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        begins a vector when idle; ignored otherwise
//   len          chunk count, sampled on an accepted start
//   chunk_valid  chunk_data/chunk_wgt valid
//   chunk_ready  controller accepts a chunk this cycle
//   chunk_data   activation bits of the current chunk
//   chunk_wgt    weight bits (XNOR build only)
//   res_valid    result valid, held until res_ready
//   res_ready    downstream accepts the result
//   res_sum      accumulated popcount
//   res_sat      accumulator saturated during this vector
//   busy         controller not idle
// ---------------------------------------------------------------------------
module popcount_seq #(
    parameter int LEN_W = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             chunk_valid,
    output logic             chunk_ready,
    input  logic [9:0]       chunk_data,
    input  logic [9:0]       chunk_wgt,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_sum,
    output logic             res_sat,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_reg;
    logic [LEN_W-1:0] cnt_reg;
    logic [3:0]       pcnt_reg;
    logic             pcnt_vld_reg;
    logic [ACC_W-1:0] acc_reg;
    logic             sat_reg;
    logic             chunk_ready_reg;
    logic             res_valid_reg;
    logic             busy_reg;

    // ---------------------------------------------------------------
    // Compressor input selection
    // ---------------------------------------------------------------
    logic [9:0] comp_in;

`ifdef POPCNT_XNOR_EN
    assign comp_in = ~(chunk_data ^ chunk_wgt);
`else
    logic unused_wgt;
    assign comp_in    = chunk_data;
    assign unused_wgt = ^chunk_wgt;
`endif

    // ---------------------------------------------------------------
    // 10-to-4 compressor: purely combinational bit count. Built as a
    // running sum so synthesis is free to map it to a compressor tree.
    // ---------------------------------------------------------------
    logic [3:0] psum [0:10];

    assign psum[0] = 4'd0;

    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_count
            assign psum[gi+1] = psum[gi] + {3'b000, comp_in[gi]};
        end
    endgenerate

    // ---------------------------------------------------------------
    // Stage-2 saturating add. One extra bit catches the carry-out.
    // ---------------------------------------------------------------
    logic [ACC_W:0] acc_sum;

    assign acc_sum = {1'b0, acc_reg} + {{(ACC_W-3){1'b0}}, pcnt_reg};

    wire handshake = chunk_valid && chunk_ready_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            pcnt_reg        <= '0;
            pcnt_vld_reg    <= 1'b0;
            acc_reg         <= '0;
            sat_reg         <= 1'b0;
            chunk_ready_reg <= 1'b0;
            res_valid_reg   <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            // Stage 2 runs whenever stage 1 holds a count. This is
            // independent of the FSM, so the last count is absorbed
            // during DRAIN.
            if (pcnt_vld_reg) begin
                if (acc_sum[ACC_W]) begin
                    acc_reg <= '1;
                    sat_reg <= 1'b1;
                end else begin
                    acc_reg <= acc_sum[ACC_W-1:0];
                end
            end

            // Stage 1 is valid only on the cycle after a handshake.
            // Gaps in the stream leave bubbles in the pipeline.
            pcnt_vld_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        cnt_reg  <= len;
                        acc_reg  <= '0;
                        sat_reg  <= 1'b0;
                        busy_reg <= 1'b1;
                        if (len != '0) begin
                            state_reg       <= RUN;
                            chunk_ready_reg <= 1'b1;
                        end else begin
                            state_reg     <= DONE;
                            res_valid_reg <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (handshake) begin
                        pcnt_reg     <= psum[10];
                        pcnt_vld_reg <= 1'b1;
                        cnt_reg      <= cnt_reg - 1'b1;
                        if (cnt_reg == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                            state_reg       <= DRAIN;
                            chunk_ready_reg <= 1'b0;
                        end
                    end
                end

                DRAIN: begin
                    state_reg     <= DONE;
                    res_valid_reg <= 1'b1;
                end

                DONE: begin
                    // A start pulse arriving here is dropped. The FSM
                    // only looks at start in IDLE.
                    if (res_ready) begin
                        state_reg     <= IDLE;
                        res_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign chunk_ready = chunk_ready_reg;
    assign res_valid   = res_valid_reg;
    assign res_sum     = acc_reg;
    assign res_sat     = sat_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_popcount_seq.sv
// ---------------------------------------------------------------------------
// Testbench for popcount_seq.
//
// Two instances share one stimulus stream:
//   ACC_W=16  is the wide accumulator.
//   ACC_W=4   exercises saturation.
//
// The reference model tracks the phase of the transaction and the total of
// the chunk bit counts. The expected result is the total clipped to the
// accumulator maximum. Saturation is expected when the total exceeds that
// maximum.
// ---------------------------------------------------------------------------
module tb_popcount_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] len;
    logic       chunk_valid;
    logic [9:0] chunk_data;
    logic [9:0] chunk_wgt;
    logic       res_ready;

    logic        a_chunk_ready, a_res_valid, a_res_sat, a_busy;
    logic [15:0] a_res_sum;
    logic        b_chunk_ready, b_res_valid, b_res_sat, b_busy;
    logic [3:0]  b_res_sum;

    always #5 clk = ~clk;

    popcount_seq #(.LEN_W(8), .ACC_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .chunk_valid(chunk_valid), .chunk_ready(a_chunk_ready),
        .chunk_data(chunk_data), .chunk_wgt(chunk_wgt),
        .res_valid(a_res_valid), .res_ready(res_ready),
        .res_sum(a_res_sum), .res_sat(a_res_sat), .busy(a_busy)
    );

    popcount_seq #(.LEN_W(8), .ACC_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .chunk_valid(chunk_valid), .chunk_ready(b_chunk_ready),
        .chunk_data(chunk_data), .chunk_wgt(chunk_wgt),
        .res_valid(b_res_valid), .res_ready(res_ready),
        .res_sum(b_res_sum), .res_sat(b_res_sat), .busy(b_busy)
    );

    int checks = 0;
    int failures = 0;
    int ready_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Bit count of one chunk, as the compressor must produce it.
    function automatic int chunk_count(input logic [9:0] d, input logic [9:0] w);
`ifdef POPCNT_XNOR_EN
        return $countones(~(d ^ w));
`else
        return $countones(d) + 0 * $countones(w);
`endif
    endfunction

    // ---------------------------------------------------------------
    // Reference model.
    // Phases: 0 idle, 1 taking chunks, 2 draining, 3 result pending.
    // ---------------------------------------------------------------
    int m_phase = 0;
    int m_left  = 0;
    int m_total = 0;
    bit m_known = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_total = 0;
            m_left  = 0;
            m_known = 1'b1;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_total = 0;
                    m_left  = int'(len);
                    m_phase = (len == 8'd0) ? 3 : 1;
                end
                1: if (chunk_valid) begin
                    m_total += chunk_count(chunk_data, chunk_wgt);
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                2: m_phase = 3;
                default: if (res_ready) m_phase = 0;
            endcase
        end
    end

    // Compare process: outputs are checked on every cycle against the model.
    always @(negedge clk) begin
        if (m_known) begin
            chk("busy16",        a_busy,        m_phase != 0);
            chk("chunk_ready16", a_chunk_ready, m_phase == 1);
            chk("res_valid16",   a_res_valid,   m_phase == 3);
            chk("busy4",         b_busy,        m_phase != 0);
            chk("chunk_ready4",  b_chunk_ready, m_phase == 1);
            chk("res_valid4",    b_res_valid,   m_phase == 3);
            if (m_phase == 3) begin
                chk("res_sum16", a_res_sum, (m_total > 65535) ? 65535 : m_total);
                chk("res_sat16", a_res_sat, m_total > 65535);
                chk("res_sum4",  b_res_sum, (m_total > 15) ? 15 : m_total);
                chk("res_sat4",  b_res_sat, m_total > 15);
            end
            if (a_chunk_ready) ready_cycles++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [9:0] vd [0:7];
    logic [9:0] vw [0:7];

    // Runs one vector from start through the result handshake.
    // n: chunk count; gap: idle cycles between chunks;
    // hold: cycles res_ready is held low; spam: start is kept high with
    // another len while the vector is busy.
    task automatic run_vec(input int n, input int gap, input int hold, input bit spam,
                           input int exp16, input int exp4, input int sat4);
        int idx;
        int cyc;
        int lat;
        bit hs;
        start = 1'b1;
        len   = n[7:0];
        tick;
        if (spam) len = 8'd7;
        else start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 100) begin
            chunk_valid = 1'b1;
            chunk_data  = vd[idx];
            chunk_wgt   = vw[idx];
            @(negedge clk);
            hs = a_chunk_ready;
            tick;
            if (hs) begin
                idx++;
                chunk_valid = 1'b0;
                if (idx < n) repeat (gap) tick;
            end
            cyc++;
        end
        chunk_valid = 1'b0;
        chk("chunks_accepted", idx, n);
        lat = 0;
        while (!a_res_valid && lat < 20) begin
            tick;
            lat++;
        end
        chk("result_latency", lat, (n == 0) ? 0 : 1);
        chk("res_valid_seen", a_res_valid, 1);
        chk("lit_res_sum16", a_res_sum, exp16);
        chk("lit_res_sum4",  b_res_sum, exp4);
        chk("lit_res_sat4",  b_res_sat, sat4);
        repeat (hold) tick;
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        start     = 1'b0;
        chk("busy_after_handshake", a_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; chunk_valid = 1'b0;
        chunk_data = '0; chunk_wgt = '0; res_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vd[i] = '0;
            vw[i] = '0;
        end
        tick; tick;
        rst = 1'b0;
        chk("rst_res_valid",   a_res_valid,   0);
        chk("rst_chunk_ready", a_chunk_ready, 0);
        chk("rst_busy",        a_busy,        0);
        chk("rst_res_sum",     a_res_sum,     0);
        chk("rst_res_sat",     a_res_sat,     0);
        tick;

        // Back-to-back chunks: 10 + 0 + 5.
        vd[0] = 10'h3FF; vd[1] = 10'h000; vd[2] = 10'h155;
        ready_cycles = 0;
        run_vec(3, 0, 0, 1'b0, 15, 15, 0);
        chk("ready_cycles", ready_cycles, 3);
        tick;

        // Gaps between chunks, and a back-pressured result.
        run_vec(3, 2, 5, 1'b0, 15, 15, 0);
        tick;

        // Empty vector, with start pulses during DONE.
        run_vec(0, 0, 2, 1'b1, 0, 0, 0);
        tick;

        // Start pulses during RUN and DONE must not resample len.
        vd[0] = 10'h00F; vd[1] = 10'h0F0;
        run_vec(2, 1, 2, 1'b1, 8, 8, 0);
        tick;

        // 20 ones: the 4-bit accumulator saturates.
        vd[0] = 10'h3FF; vd[1] = 10'h3FF;
        run_vec(2, 0, 0, 1'b0, 20, 15, 1);
        tick;

        // Matching weights, then complementary weights.
        vd[0] = 10'h2AA; vw[0] = 10'h2AA;
`ifdef POPCNT_XNOR_EN
        run_vec(1, 0, 0, 1'b0, 10, 10, 0);
`else
        run_vec(1, 0, 0, 1'b0, 5, 5, 0);
`endif
        vw[0] = 10'h155;
`ifdef POPCNT_XNOR_EN
        run_vec(1, 0, 0, 1'b0, 0, 0, 0);
`else
        run_vec(1, 0, 0, 1'b0, 5, 5, 0);
`endif
        vw[0] = 10'h000;
        tick;

        // Reset mid-vector after 2 of 4 chunks.
        start = 1'b1; len = 8'd4;
        tick;
        start = 1'b0;
        chunk_valid = 1'b1; chunk_data = 10'h3FF;
        tick; tick;
        chunk_valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_res_valid",   a_res_valid,   0);
        chk("abort_chunk_ready", a_chunk_ready, 0);
        chk("abort_busy",        a_busy,        0);
        chk("abort_res_sum",     a_res_sum,     0);
        chk("abort_res_sat",     b_res_sat,     0);
        tick;
        vd[0] = 10'h001;
        run_vec(1, 0, 0, 1'b0, 1, 1, 0);
        tick; tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
